display_timing_gen: RTL and testbench
=====================================

Name: display_timing_gen

Overview:
Generates raster timing for the DVI output path: horizontal and vertical position counters, sync pulses, display enable and line/frame strobes. It sits directly upstream of the three per-channel TMDS encoders. o_de drives each encoder's display-enable input, and o_ctrl drives the blue-channel control input. Pixel generators use o_sx, o_sy and the strobes to produce colour data aligned with o_de.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width (cycles)
H_BP, 48, horizontal back porch (cycles)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CORDW, 16, width of position outputs

Ports:
i_clk  input  1  pixel clock
i_rst  input  1  synchronous reset, active-low
i_en  input  1  advance enable; raster moves one pixel per cycle with i_en=1
o_hs  output  1  horizontal sync, at pin polarity
o_vs  output  1  vertical sync, at pin polarity
o_de  output  1  display enable, high in the active region
o_ctrl  output  2  {o_vs, o_hs}, for the TMDS encoder control input
o_sx  output  CORDW  horizontal position, 0..H_TOTAL-1
o_sy  output  CORDW  vertical position, 0..V_TOTAL-1
o_line  output  1  one-cycle strobe when the raster is at sx=0
o_frame  output  1  one-cycle strobe when the raster is at sx=0, sy=0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration checks, fatal on failure:
  - every timing parameter >= 1;
  - 2^CORDW > max(H_TOTAL, V_TOTAL).
- Raster layout: each line runs active, front porch, sync, back porch; position 0 is the first active pixel. Frames use the same order vertically.
- All outputs are registered and mutually aligned: in any cycle they describe the single position (o_sx, o_sy).
- Reset (i_rst=0 at a clock edge):
  - o_sx=0, o_sy=0, o_de=0, o_line=0, o_frame=0;
  - o_hs=~H_POL and o_vs=~V_POL (inactive levels); o_ctrl follows them.
- First enabled edge after reset release presents (0,0) with o_de=1, o_line=1, o_frame=1.
- Each later enabled edge advances the position:
  - sx = sx+1; at H_TOTAL-1, sx wraps to 0 and sy increments;
  - at sy=V_TOTAL-1 with sx=H_TOTAL-1, both wrap to 0.
- Decode of each presented position:
  - o_de = (sx < H_ACTIVE) && (sy < V_ACTIVE);
  - hsync active when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC;
  - vsync active when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC; it changes only together with sy, i.e. at sx=0;
  - o_hs = H_POL when hsync active, else ~H_POL; o_vs likewise with V_POL.
- Stall: an edge with i_en=0 holds o_sx, o_sy, o_de, o_hs, o_vs and o_ctrl. It forces o_line=0 and o_frame=0, so each strobe is exactly one cycle per line/frame regardless of stall pattern.
- Reset mid-frame: reset wins over i_en; the raster restarts at (0,0) on the first enabled edge after release. No partial-frame recovery.
- Latency: one cycle from an enabled edge to its outputs. Downstream pixel logic registering colour from o_sx/o_sy must delay o_de/o_ctrl by its own pipeline depth.

Decomposition:
- Shared package video_timing_pkg:
  - mode preset constants for 640x480@60 and 1280x720@60 (the eight timing values and both polarities);
  - TMDS control-code constants shared with the encoders.
- No sub-module. The two wrap counters and the window compares are inline.

Test Plan:
1. Defaults; hold reset 5 cycles, release with i_en=1 -> reset values match Behaviour; first cycle after release gives o_sx=0, o_sy=0, o_de=1, o_line=1, o_frame=1.
2. Defaults, run 2 lines -> per line o_de high 640 cycles then low 160; o_hs low exactly at sx 656..751 (96 cycles); o_line period 800; o_ctrl[0]==o_hs every cycle.
3. Defaults, run 2 frames (840000 cycles) -> o_frame period 420000; o_de high 307200 cycles per frame; o_vs low exactly for sy 490..491 (1600 cycles), edges at sx=0; o_sy max 524.
4. i_en toggling 1,0,1,0... -> position sequence identical to case 2 at half rate; o_line high only on enabled cycles with sx=0, never 2 cycles in a row.
5. Assert reset at sx=300, sy=200 for 1 cycle -> reset values next cycle; after release raster restarts at (0,0) with o_frame=1.
6. 1280x720 preset (110/40/220, 5/5/20, H_POL=V_POL=1) -> H_TOTAL 1650, V_TOTAL 750; o_hs high at sx 1390..1429; o_vs high at sy 725..729; o_ctrl=2'b00 outside sync.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: mode presets for the raster generator
// and the TMDS control-period codes used by the channel encoders.
package video_timing_pkg;

  // One complete raster mode: the eight timing values plus sync polarities.
  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic h_pol;
    logic v_pol;
  } timing_t;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low.
  localparam timing_t MODE_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, both syncs active-high.
  localparam timing_t MODE_1280X720 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    h_pol: 1'b1, v_pol: 1'b1
  };

  // TMDS control-period symbols, indexed by {c1, c0}.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/display_timing_gen.sv
// Raster timing generator: position counters, sync pulses, display enable
// and line/frame strobes, all registered and describing one position.
module display_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = MODE_640X480.h_active,
  parameter int   H_FP     = MODE_640X480.h_fp,
  parameter int   H_SYNC   = MODE_640X480.h_sync,
  parameter int   H_BP     = MODE_640X480.h_bp,
  parameter int   V_ACTIVE = MODE_640X480.v_active,
  parameter int   V_FP     = MODE_640X480.v_fp,
  parameter int   V_SYNC   = MODE_640X480.v_sync,
  parameter int   V_BP     = MODE_640X480.v_bp,
  parameter logic H_POL    = MODE_640X480.h_pol,
  parameter logic V_POL    = MODE_640X480.v_pol,
  parameter int   CORDW    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [1:0]       o_ctrl,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_line,
  output logic             o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "display_timing_gen: every timing value must be at least 1");
  end
  if ((64'(1) << CORDW) <= 64'(H_TOTAL) || (64'(1) << CORDW) <= 64'(V_TOTAL)) begin : g_bad_cordw
    $fatal(1, "display_timing_gen: CORDW too narrow for the raster totals");
  end

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  // Enable semantics: i_en=1 at an edge moves the raster one pixel; i_en=0
  // holds every output except the strobes, which drop for that cycle.
  // primed is low until the first enabled edge after reset, which presents
  // (0,0) instead of advancing.
  logic             primed;
  logic [CORDW-1:0] nx;
  logic [CORDW-1:0] ny;
  logic             n_de;
  logic             n_hs;
  logic             n_vs;

  // Next position to present, plus its decoded sync/enable levels.
  always_comb begin
    nx = '0;
    ny = '0;
    if (primed) begin
      if (o_sx == H_LAST) begin
        nx = '0;
        ny = (o_sy == V_LAST) ? '0 : o_sy + 1'b1;
      end else begin
        nx = o_sx + 1'b1;
        ny = o_sy;
      end
    end
    n_de = (nx < H_ACT_C) && (ny < V_ACT_C);
    n_hs = ((nx >= HS_START) && (nx < HS_END)) ? H_POL : ~H_POL;
    n_vs = ((ny >= VS_START) && (ny < VS_END)) ? V_POL : ~V_POL;
  end

  // Register position and decode together so all outputs stay aligned.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      primed  <= 1'b0;
      o_sx    <= '0;
      o_sy    <= '0;
      o_de    <= 1'b0;
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_ctrl  <= {~V_POL, ~H_POL};
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else if (i_en) begin
      primed  <= 1'b1;
      o_sx    <= nx;
      o_sy    <= ny;
      o_de    <= n_de;
      o_hs    <= n_hs;
      o_vs    <= n_vs;
      o_ctrl  <= {n_vs, n_hs};
      o_line  <= (nx == '0);
      o_frame <= (nx == '0) && (ny == '0);
    end else begin
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: three instances (640x480, 1280x720 and a
// tiny mode that wraps whole frames quickly) share one stimulus stream and
// are compared every cycle against a position-index reference model, plus
// a table of hand-derived checkpoints for the 640x480 instance.
module tb_display_timing_gen;
  import video_timing_pkg::*;

  localparam timing_t MODE_TINY = '{
    h_active: 8, h_fp: 2, h_sync: 3, h_bp: 2,
    v_active: 4, v_fp: 1, v_sync: 2, v_bp: 1,
    h_pol: 1'b1, v_pol: 1'b0
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic        a_hs, a_vs, a_de, a_line, a_frame;
  logic [1:0]  a_ctrl;
  logic [15:0] a_sx, a_sy;
  logic        b_hs, b_vs, b_de, b_line, b_frame;
  logic [1:0]  b_ctrl;
  logic [15:0] b_sx, b_sy;
  logic        c_hs, c_vs, c_de, c_line, c_frame;
  logic [1:0]  c_ctrl;
  logic [3:0]  c_sx, c_sy;

  display_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_ctrl(a_ctrl),
    .o_sx(a_sx), .o_sy(a_sy), .o_line(a_line), .o_frame(a_frame)
  );

  display_timing_gen #(
    .H_ACTIVE(MODE_1280X720.h_active), .H_FP(MODE_1280X720.h_fp),
    .H_SYNC(MODE_1280X720.h_sync), .H_BP(MODE_1280X720.h_bp),
    .V_ACTIVE(MODE_1280X720.v_active), .V_FP(MODE_1280X720.v_fp),
    .V_SYNC(MODE_1280X720.v_sync), .V_BP(MODE_1280X720.v_bp),
    .H_POL(MODE_1280X720.h_pol), .V_POL(MODE_1280X720.v_pol), .CORDW(16)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_ctrl(b_ctrl),
    .o_sx(b_sx), .o_sy(b_sy), .o_line(b_line), .o_frame(b_frame)
  );

  display_timing_gen #(
    .H_ACTIVE(MODE_TINY.h_active), .H_FP(MODE_TINY.h_fp),
    .H_SYNC(MODE_TINY.h_sync), .H_BP(MODE_TINY.h_bp),
    .V_ACTIVE(MODE_TINY.v_active), .V_FP(MODE_TINY.v_fp),
    .V_SYNC(MODE_TINY.v_sync), .V_BP(MODE_TINY.v_bp),
    .H_POL(MODE_TINY.h_pol), .V_POL(MODE_TINY.v_pol), .CORDW(4)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hs(c_hs), .o_vs(c_vs), .o_de(c_de), .o_ctrl(c_ctrl),
    .o_sx(c_sx), .o_sy(c_sy), .o_line(c_line), .o_frame(c_frame)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int sx;
    int sy;
    bit de;
    bit hs;
    bit vs;
    bit line;
    bit frame;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // Enabled edges since the last reset; the presented pixel is number n-1
  // counted from the start of the raster.
  int n_enabled = 0;
  bit last_adv  = 1'b0;

  function automatic obs_t model(timing_t m, int n, bit adv);
    obs_t o;
    int ht, vt, idx, hs0, vs0;
    ht  = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    vt  = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    hs0 = m.h_active + m.h_fp;
    vs0 = m.v_active + m.v_fp;
    if (n == 0) begin
      o = '{sx: 0, sy: 0, de: 1'b0, hs: ~m.h_pol, vs: ~m.v_pol, line: 1'b0, frame: 1'b0};
    end else begin
      idx     = n - 1;
      o.sx    = idx % ht;
      o.sy    = (idx / ht) % vt;
      o.de    = (o.sx < m.h_active) && (o.sy < m.v_active);
      o.hs    = (o.sx >= hs0 && o.sx < hs0 + m.h_sync) ? m.h_pol : ~m.h_pol;
      o.vs    = (o.sy >= vs0 && o.sy < vs0 + m.v_sync) ? m.v_pol : ~m.v_pol;
      o.line  = adv && (o.sx == 0);
      o.frame = adv && (o.sx == 0) && (o.sy == 0);
    end
    return o;
  endfunction

  task automatic compare(string name, obs_t e, obs_t a, logic [1:0] ctrl);
    total++;
    if (e != a || ctrl != {e.vs, e.hs}) begin
      bad++;
      $display("FAIL %s t=%0t got sx=%0d sy=%0d de=%0b hs=%0b vs=%0b ctrl=%b line=%0b frame=%0b want sx=%0d sy=%0d de=%0b hs=%0b vs=%0b ctrl=%b line=%0b frame=%0b",
               name, $time, a.sx, a.sy, a.de, a.hs, a.vs, ctrl, a.line, a.frame,
               e.sx, e.sy, e.de, e.hs, e.vs, {e.vs, e.hs}, e.line, e.frame);
    end
  endtask

  function automatic obs_t grab_a();
    return '{sx: int'(a_sx), sy: int'(a_sy), de: a_de, hs: a_hs, vs: a_vs, line: a_line, frame: a_frame};
  endfunction

  // ---------------- driver ----------------
  // Apply one cycle of inputs, let the edge happen, then check all DUTs.
  task automatic drive_cycle(bit r, bit e);
    obs_t act;
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    if (!r) begin
      n_enabled = 0;
      last_adv  = 1'b0;
    end else begin
      last_adv = e;
      if (e) n_enabled++;
    end
    compare("mode640", model(MODE_640X480, n_enabled, last_adv), grab_a(), a_ctrl);
    act = '{sx: int'(b_sx), sy: int'(b_sy), de: b_de, hs: b_hs, vs: b_vs, line: b_line, frame: b_frame};
    compare("mode720", model(MODE_1280X720, n_enabled, last_adv), act, b_ctrl);
    act = '{sx: int'(c_sx), sy: int'(c_sy), de: c_de, hs: c_hs, vs: c_vs, line: c_line, frame: c_frame};
    compare("modetiny", model(MODE_TINY, n_enabled, last_adv), act, c_ctrl);
  endtask

  // ---------------- checkpoint table ----------------
  // en_mode: 0 off, 1 on, 2 alternating starting on, 3 random,
  //          4 random with occasional reset pulses
  typedef struct {
    bit   rst;
    int   en_mode;
    int   ncyc;
    bit   chk;
    obs_t exp;
  } vec_t;

  localparam obs_t RST_A = '{sx: 0, sy: 0, de: 1'b0, hs: 1'b1, vs: 1'b1, line: 1'b0, frame: 1'b0};

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{rst: 1'b0, en_mode: 1, ncyc: 5,    chk: 1'b1, exp: RST_A};
    vecs[1]  = '{rst: 1'b1, en_mode: 1, ncyc: 1,    chk: 1'b1,
                 exp: '{sx: 0,   sy: 0, de: 1'b1, hs: 1'b1, vs: 1'b1, line: 1'b1, frame: 1'b1}};
    vecs[2]  = '{rst: 1'b1, en_mode: 1, ncyc: 656,  chk: 1'b1,
                 exp: '{sx: 656, sy: 0, de: 1'b0, hs: 1'b0, vs: 1'b1, line: 1'b0, frame: 1'b0}};
    vecs[3]  = '{rst: 1'b1, en_mode: 0, ncyc: 3,    chk: 1'b1,
                 exp: '{sx: 656, sy: 0, de: 1'b0, hs: 1'b0, vs: 1'b1, line: 1'b0, frame: 1'b0}};
    vecs[4]  = '{rst: 1'b1, en_mode: 1, ncyc: 144,  chk: 1'b1,
                 exp: '{sx: 0,   sy: 1, de: 1'b1, hs: 1'b1, vs: 1'b1, line: 1'b1, frame: 1'b0}};
    vecs[5]  = '{rst: 1'b1, en_mode: 2, ncyc: 1600, chk: 1'b1,
                 exp: '{sx: 0,   sy: 2, de: 1'b1, hs: 1'b1, vs: 1'b1, line: 1'b0, frame: 1'b0}};
    vecs[6]  = '{rst: 1'b1, en_mode: 3, ncyc: 2000, chk: 1'b0, exp: RST_A};
    vecs[7]  = '{rst: 1'b0, en_mode: 1, ncyc: 1,    chk: 1'b1, exp: RST_A};
    vecs[8]  = '{rst: 1'b1, en_mode: 0, ncyc: 2,    chk: 1'b1, exp: RST_A};
    vecs[9]  = '{rst: 1'b1, en_mode: 1, ncyc: 1,    chk: 1'b1,
                 exp: '{sx: 0,   sy: 0, de: 1'b1, hs: 1'b1, vs: 1'b1, line: 1'b1, frame: 1'b1}};
    vecs[10] = '{rst: 1'b1, en_mode: 1, ncyc: 300,  chk: 1'b1,
                 exp: '{sx: 300, sy: 0, de: 1'b1, hs: 1'b1, vs: 1'b1, line: 1'b0, frame: 1'b0}};
    vecs[11] = '{rst: 1'b0, en_mode: 0, ncyc: 1,    chk: 1'b1, exp: RST_A};
    vecs[12] = '{rst: 1'b1, en_mode: 4, ncyc: 3000, chk: 1'b0, exp: RST_A};
    vecs[13] = '{rst: 1'b1, en_mode: 1, ncyc: 1700, chk: 1'b0, exp: RST_A};

    for (int v = 0; v < 14; v++) begin
      for (int k = 0; k < vecs[v].ncyc; k++) begin
        bit r, e;
        r = vecs[v].rst;
        case (vecs[v].en_mode)
          0:       e = 1'b0;
          1:       e = 1'b1;
          2:       e = (k % 2 == 0);
          default: e = ($urandom_range(0, 3) != 0);
        endcase
        if (vecs[v].en_mode == 4 && $urandom_range(0, 149) == 0) r = 1'b0;
        drive_cycle(r, e);
      end
      if (vecs[v].chk) begin
        string nm;
        nm = $sformatf("row%0d", v);
        compare(nm, vecs[v].exp, grab_a(), a_ctrl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
